key_led_mode_ctrl: RTL and testbench
====================================

// Module: key_led_mode_ctrl
// PURPOSE
//   Sequences the board LED from one debounced key.
//   - Sits downstream of key_debounce and consumes its key_flag press pulse and key_value level.
//   - Classifies each press as short or long.
//   - Runs a 4-mode LED state machine: OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF.
//   - A long press forces OFF from any mode.
// PARAMETERS
//   LONG_CNT   50_000_000  hold cycles that make a press long (1 s @ 50 MHz)
//   SLOW_HALF  25_000_000  half-period of BLINK_SLOW in cycles (1 Hz)
//   FAST_HALF   6_250_000  half-period of BLINK_FAST in cycles (4 Hz)
// PORTS
//   sys_clk    in   1  single clock; all logic on rising edge
//   sys_rst    in   1  reset: synchronous, active-high
//   key_flag   in   1  1-cycle pulse from debouncer on debounced press
//   key_value  in   1  debounced key level; 0 = pressed, 1 = released
//   led_out    out  1  LED drive, active-low (1 = dark)
//   mode       out  2  current mode: 0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST
//   short_evt  out  1  1-cycle pulse: short press classified
//   long_evt   out  1  1-cycle pulse: long press classified
// BEHAVIOUR
//   Reset: on sys_rst high at a clock edge, all outputs and state return to these values:
//     led_out=1, mode=0, short_evt=0, long_evt=0, press FSM=IDLE, counters=0, blink phase=lit.
//     This applies mid-press and mid-blink; no event is emitted for an interrupted press.
//   Press FSM (registered):
//     IDLE: key_flag=1 -> HELD, hold_cnt<=0. key_value is ignored in IDLE.
//     HELD, key_value=1: release. If hold_cnt < LONG_CNT-1: short_evt=1 next cycle -> IDLE.
//     HELD, key_value=0: hold_cnt increments. When hold_cnt == LONG_CNT-1: long_evt=1 next cycle -> WAIT_REL.
//       A long press therefore fires exactly LONG_CNT cycles after the key_flag cycle.
//     WAIT_REL: key_value=1 -> IDLE. No further event for this press.
//     key_flag outside IDLE is ignored.
//     key_flag with key_value=1 in the same IDLE cycle -> HELD; release seen next cycle -> short.
//     hold_cnt width = $clog2(LONG_CNT); it saturates and never wraps.
//   Mode FSM:
//     On the cycle short_evt=1, mode <= mode+1, wrapping 3 -> 0.
//     On the cycle long_evt=1, mode <= 0.
//     short_evt and long_evt are mutually exclusive by construction.
//   Blink generator:
//     blink_cnt and phase clear to 0/lit on every mode change.
//     In BLINK_SLOW, phase toggles when blink_cnt == SLOW_HALF-1, then blink_cnt <= 0.
//     In BLINK_FAST, the same rule applies with FAST_HALF.
//     In OFF and ON, blink_cnt is held at 0.
//   led_out (registered, 1 cycle after mode): OFF -> 1, ON -> 0, BLINK -> 0 when lit, 1 when dark.
//   Latency: release sample -> short_evt 1 cycle; short_evt -> mode 1 cycle; mode -> led_out 1 cycle.
// STRUCTURE
//   Package key_led_pkg:
//     mode encodings MODE_OFF/ON/SLOW/FAST (2-bit localparams)
//     press FSM state encodings ST_IDLE/ST_HELD/ST_WAIT_REL
//     default timing constants
//   Sub-module key_press_classifier: the press FSM plus hold_cnt; outputs short_evt/long_evt.
//   Top: mode register, blink counter/phase, led_out register.
// TESTING (bench params LONG_CNT=20, SLOW_HALF=8, FAST_HALF=2)
//   Reset: hold sys_rst 3 cycles -> led_out=1, mode=0, no event pulses.
//   Short presses: key_flag then key_value=0 for 5 cycles, then 1 -> one short_evt, mode 0->1, led_out=0;
//     3 more -> mode 2, 3, then wraps to 0.
//   Long press: from mode=2 hold 25 cycles -> long_evt exactly 20 cycles after key_flag, mode=0,
//     no short_evt on release.
//   Blink timing: mode=2 -> led_out toggles every 8 cycles; mode=3 -> toggles every 2 cycles;
//     first toggle 8 (or 2) cycles after the mode change.
//   Ignore rule: second key_flag while HELD -> no extra event; only one classification per press.
//   Reset mid-press: sys_rst at hold_cnt=10 -> no event emitted; a new press afterwards classifies normally.

Source files
------------

// File: rtl/key_led_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// key_led_pkg : shared encodings and default timing for key_led_mode_ctrl
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
package key_led_pkg;

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_ON   = 2'd1;
  localparam logic [1:0] MODE_SLOW = 2'd2;
  localparam logic [1:0] MODE_FAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HELD     = 2'd1,
    ST_WAIT_REL = 2'd2
  } press_state_e;

  localparam int unsigned DEF_LONG_CNT  = 50_000_000;
  localparam int unsigned DEF_SLOW_HALF = 25_000_000;
  localparam int unsigned DEF_FAST_HALF = 6_250_000;

endpackage
`default_nettype wire

// File: rtl/key_press_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// key_press_classifier : turns a debounced press into a short or long event
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module key_press_classifier
  import key_led_pkg::*;
#(
  parameter int unsigned LONG_CNT = DEF_LONG_CNT
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_flag,
  input  logic key_value,
  output logic short_evt,
  output logic long_evt
);

  localparam int unsigned CW = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  press_state_e  state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          short_evt_q, short_evt_d;
  logic          long_evt_q, long_evt_d;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    short_evt_d = 1'b0;
    long_evt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_flag) begin
          state_d    = ST_HELD;
          hold_cnt_d = '0;
        end
      end
      ST_HELD: begin
        // A release landing exactly on the long threshold is dropped silently.
        if (key_value) begin
          state_d     = ST_IDLE;
          short_evt_d = (hold_cnt_q < CNT_LAST);
        end else if (hold_cnt_q == CNT_LAST) begin
          state_d    = ST_WAIT_REL;
          long_evt_d = 1'b1;
        end else if (hold_cnt_q != CNT_SAT) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (key_value) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      short_evt_q <= 1'b0;
      long_evt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      short_evt_q <= short_evt_d;
      long_evt_q  <= long_evt_d;
    end
  end

  assign short_evt = short_evt_q;
  assign long_evt  = long_evt_q;

endmodule
`default_nettype wire

// File: rtl/key_led_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// key_led_mode_ctrl : single-key LED mode sequencer (OFF/ON/SLOW/FAST blink)
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module key_led_mode_ctrl
  import key_led_pkg::*;
#(
  parameter int unsigned LONG_CNT  = DEF_LONG_CNT,
  parameter int unsigned SLOW_HALF = DEF_SLOW_HALF,
  parameter int unsigned FAST_HALF = DEF_FAST_HALF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_flag,
  input  logic       key_value,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       short_evt,
  output logic       long_evt
);

  localparam int unsigned MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int unsigned BW = $clog2(MAX_HALF + 1);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);

  logic [1:0]    mode_q, mode_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [BW-1:0] half_last;
  logic          phase_q, phase_d;
  logic          led_q, led_d;

  key_press_classifier #(
    .LONG_CNT (LONG_CNT)
  ) u_classifier (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_flag  (key_flag),
    .key_value (key_value),
    .short_evt (short_evt),
    .long_evt  (long_evt)
  );

  always_comb begin
    mode_d = mode_q;
    if (long_evt)       mode_d = MODE_OFF;
    else if (short_evt) mode_d = mode_q + 2'd1;

    half_last   = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    // phase 0 is the lit half; every mode change restarts the blink cleanly
    if (mode_d != mode_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (mode_q == MODE_SLOW || mode_q == MODE_FAST) begin
      if (blink_cnt_q == half_last) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end

    case (mode_q)
      MODE_OFF: led_d = 1'b1;
      MODE_ON:  led_d = 1'b0;
      default:  led_d = phase_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= 1'b1;
    end else begin
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  assign mode    = mode_q;
  assign led_out = led_q;

endmodule
`default_nettype wire

// File: tb/tb_key_led_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_key_led_mode_ctrl : scoreboard bench for key_led_mode_ctrl
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_key_led_mode_ctrl;

  localparam int LONG_CNT  = 20;
  localparam int SLOW_HALF = 8;
  localparam int FAST_HALF = 2;

  logic       sys_clk   = 1'b0;
  logic       sys_rst   = 1'b1;
  logic       key_flag  = 1'b0;
  logic       key_value = 1'b1;
  logic       led_out;
  logic [1:0] mode;
  logic       short_evt;
  logic       long_evt;

  key_led_mode_ctrl #(
    .LONG_CNT  (LONG_CNT),
    .SLOW_HALF (SLOW_HALF),
    .FAST_HALF (FAST_HALF)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_flag  (key_flag),
    .key_value (key_value),
    .led_out   (led_out),
    .mode      (mode),
    .short_evt (short_evt),
    .long_evt  (long_evt)
  );

  always #5 sys_clk = ~sys_clk;

  // cyc == n after the n-th rising edge; all observation is on the falling edge
  int cyc = 0;
  always @(posedge sys_clk) cyc = cyc + 1;

  typedef struct {
    int val;
    int cyc_at;
  } exp_t;

  exp_t evq[$];    // val: 1 short, 2 long
  exp_t modeq[$];
  exp_t ledq[$];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // expectation planner state
  int cur_mode   = 0;
  int cur_entry  = 0;
  int planned_to = 0;
  int exp_led    = 1;

  function automatic int half_of(input int m);
    if (m == 2) return SLOW_HALF;
    if (m == 3) return FAST_HALF;
    return 0;
  endfunction

  task automatic plan_until(input int t);
    int h;
    while (planned_to < t) begin
      planned_to = planned_to + 1;
      h = half_of(cur_mode);
      if (h != 0 && planned_to > cur_entry + 1 && ((planned_to - cur_entry - 1) % h) == 0) begin
        exp_led = 1 - exp_led;
        ledq.push_back('{exp_led, planned_to});
      end
    end
  endtask

  task automatic plan_mode_change(input int m, input int at);
    int new_led;
    plan_until(at);
    modeq.push_back('{m, at});
    cur_mode  = m;
    cur_entry = at;
    new_led   = (m == 0) ? 1 : 0;
    if (new_led != exp_led) begin
      exp_led = new_led;
      ledq.push_back('{exp_led, at + 1});
    end
    planned_to = at + 1;
  endtask

  task automatic idle(input int n);
    plan_until(cyc + n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Called on a falling edge; key_flag is sampled on the next rising edge (E).
  task automatic press(input int hold, input int extra);
    int e;
    e = cyc + 1;
    if (hold <= LONG_CNT - 2) begin
      evq.push_back('{1, e + hold + 1});
      plan_mode_change((cur_mode + 1) % 4, e + hold + 2);
    end else if (hold >= LONG_CNT) begin
      evq.push_back('{2, e + LONG_CNT});
      if (cur_mode != 0) plan_mode_change(0, e + LONG_CNT + 1);
    end
    plan_until(e + hold + 2);
    key_flag  = 1'b1;
    key_value = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge sys_clk);
      key_flag = (i == extra);
    end
    @(negedge sys_clk);
    key_flag  = 1'b0;
    key_value = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic reset_mid_press(input int at_cnt);
    int e;
    int x;
    e = cyc + 1;
    x = e + at_cnt + 1;
    plan_until(x - 1);
    if (cur_mode != 0) modeq.push_back('{0, x});
    if (exp_led != 1) ledq.push_back('{1, x});
    exp_led    = 1;
    cur_mode   = 0;
    cur_entry  = x;
    planned_to = x;
    plan_until(x + 6);
    key_flag  = 1'b1;
    key_value = 1'b0;
    @(negedge sys_clk);
    key_flag = 1'b0;
    repeat (at_cnt) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    key_value = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an event or a change
  int   prev_mode = 0;
  int   prev_led  = 1;
  int   kind;
  exp_t got;
  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (short_evt || long_evt) begin
        kind   = (short_evt && long_evt) ? 3 : (short_evt ? 1 : 2);
        checks = checks + 1;
        if (evq.size() == 0) begin
          failures = failures + 1;
          $display("FAIL evt_unexpected: got kind=%0d at cyc=%0d, expected no event", kind, cyc);
        end else begin
          got = evq.pop_front();
          if (got.val != kind || got.cyc_at != cyc) begin
            failures = failures + 1;
            $display("FAIL evt: got kind=%0d at cyc=%0d, expected kind=%0d at cyc=%0d",
                     kind, cyc, got.val, got.cyc_at);
          end
        end
      end
      if (int'(mode) != prev_mode) begin
        checks = checks + 1;
        if (modeq.size() == 0) begin
          failures = failures + 1;
          $display("FAIL mode_unexpected: got mode=%0d at cyc=%0d, expected no change", mode, cyc);
        end else begin
          got = modeq.pop_front();
          if (got.val != int'(mode) || got.cyc_at != cyc) begin
            failures = failures + 1;
            $display("FAIL mode: got %0d at cyc=%0d, expected %0d at cyc=%0d",
                     mode, cyc, got.val, got.cyc_at);
          end
        end
        prev_mode = int'(mode);
      end
      if (int'(led_out) != prev_led) begin
        checks = checks + 1;
        if (ledq.size() == 0) begin
          failures = failures + 1;
          $display("FAIL led_unexpected: got led=%0d at cyc=%0d, expected no change", led_out, cyc);
        end else begin
          got = ledq.pop_front();
          if (got.val != int'(led_out) || got.cyc_at != cyc) begin
            failures = failures + 1;
            $display("FAIL led: got %0d at cyc=%0d, expected %0d at cyc=%0d",
                     led_out, cyc, got.val, got.cyc_at);
          end
        end
        prev_led = int'(led_out);
      end
    end
  end

  task automatic check_now(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    check_now("rst_led", int'(led_out), 1);
    check_now("rst_mode", int'(mode), 0);
    check_now("rst_short", int'(short_evt), 0);
    check_now("rst_long", int'(long_evt), 0);
    sys_rst    = 1'b0;
    planned_to = cyc;
    mon_en     = 1'b1;

    idle(3);
    press(5, -1);            // OFF -> ON
    idle(4);
    press(5, -1);            // ON -> SLOW
    idle(30);
    press(5, -1);            // SLOW -> FAST
    idle(12);
    press(5, -1);            // FAST -> OFF (wrap)
    press(0, -1);            // flag and release back to back: short
    press(18, -1);           // longest short press, lands in SLOW
    idle(5);
    press(25, -1);           // long press from SLOW forces OFF
    idle(5);
    press(8, 3);             // second key_flag while held is ignored
    press(5, -1);            // -> SLOW
    idle(3);
    reset_mid_press(10);     // no event, mode and LED back to reset values
    idle(3);
    press(5, -1);            // fresh press after reset classifies normally
    idle(6);

    mon_en = 1'b0;
    check_now("evq_left", evq.size(), 0);
    check_now("modeq_left", modeq.size(), 0);
    check_now("ledq_left", ledq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
